// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;

    // Wide enough for MAX_LEN up to 16 plus one guard bit, so len == MAX_LEN never overflows.
    localparam int MASK_W = 17;

    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        len_mask = (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern comparator; hit is combinational.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               step,
    input  logic               seqin,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_next, mask;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W:0]     fill_inc, len_ext;
    logic               bits_eq;

    assign hist_next = {hist_q[MAX_LEN-2:0], seqin};
    assign mask      = MAX_LEN'(len_mask(32'(pat_len)));
    assign len_ext   = {1'b0, pat_len};
    assign fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign bits_eq   = ((hist_next ^ pattern) & mask) == '0;
    assign hit       = step && (fill_inc >= len_ext) && bits_eq;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (step) begin
            hist_d = hist_next;
            // Non-overlap mode only needs fill cleared; stale history is masked out by fill.
            if (hit && !overlap)
                fill_d = '0;
            else if (fill_inc >= len_ext)
                fill_d = pat_len;
            else
                fill_d = fill_inc[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time configurable serial pattern detector: config registers, IDLE/RUN FSM,
// registered match pulse and saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seqin,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed,
    output logic               cfg_err
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               cfg_ok, step, hit;

    assign cfg_ok = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(MAX_LEN));
    // A config strobe takes priority over a coincident input bit, which is dropped.
    assign step   = in_valid && (state_q == RUN) && !cfg_load;

    seq_match_core #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (cfg_load),
        .step   (step),
        .seqin  (seqin),
        .pattern(pat_q),
        .pat_len(len_q),
        .overlap(ovl_q),
        .hit    (hit)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        dout_d  = hit;
        if (cfg_load) begin
            if (cfg_ok) begin
                state_d = RUN;
                pat_d   = cfg_pattern & MAX_LEN'(len_mask(32'(cfg_len)));
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                err_d   = 1'b0;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
        if (hit && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == RUN);
    assign cfg_err   = err_q;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector, the successor to the fixed 3-bit Mealy "101" detector. Pattern, pattern length and overlap mode are set at run time. A valid-qualified input and a saturating match counter are added. It sits on a serial bit stream and flags each completed pattern occurrence to downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of pat_len; must hold the value MAX_LEN
CNT_W, 8, width of the match counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
seqin  input  1  serial data bit
in_valid  input  1  seqin is sampled only when high
cfg_load  input  1  one-cycle strobe that latches the configuration inputs
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after a match
dout  output  1  one-cycle match pulse, registered
match_cnt  output  CNT_W  count of matches, saturating
armed  output  1  configuration valid, detector running
cfg_err  output  1  last cfg_load carried an invalid length

Behaviour:
- Reset: dout=0, match_cnt=0, armed=0, cfg_err=0. History, fill count and pattern registers are cleared. pat_len=0. State = IDLE.
- States: IDLE (no valid configuration, input ignored) and RUN (detecting).
- cfg_load is accepted in any state:
  - Valid when 1 <= cfg_len <= MAX_LEN. Latch pattern, length and overlap; clear history and fill count; go to RUN; armed=1 and cfg_err=0 from the next cycle.
  - Invalid length: go to IDLE; armed=0, cfg_err=1; match_cnt is kept.
- cfg_load together with in_valid in the same cycle: the configuration wins and that input bit is discarded.
- RUN, on each cycle with in_valid=1:
  - hist_next = {hist[MAX_LEN-2:0], seqin}.
  - fill saturates at pat_len.
  - Hit when (fill+1 >= pat_len) and the low pat_len bits of hist_next equal the low pat_len bits of the pattern.
- Latency: dout goes high in the cycle after the clock edge that samples the completing bit, and stays high for exactly one cycle.
- On a hit:
  - match_cnt increments, saturating at all-ones with no wrap.
  - Overlap=1: history is kept, so a suffix can seed the next match.
  - Overlap=0: fill is cleared to 0, so the next match needs pat_len fresh bits. hist may keep its value because it is masked by fill.
- in_valid=0: no state change and dout=0. Gaps of any length between bits are transparent.
- pat_len=1: every valid bit equal to pattern[0] is a hit in both modes.
- rst asserted mid-pattern: partial history is discarded, the configuration is lost and the block returns to IDLE. Software must reload the configuration.
- Bits of cfg_pattern above cfg_len-1 are ignored.
- Widths: compare using a mask of ((1<<pat_len)-1) computed at MAX_LEN+1 bits to avoid overflow when pat_len=MAX_LEN.

Decomposition:
- Package seq_detect_pkg:
  - State enum {IDLE, RUN}.
  - Mask-generation function for a given length.
  - Default parameter constants.
- One natural sub-module, seq_match_core: history shift register, fill counter and masked comparator. It outputs the combinational hit.
- The top level keeps the FSM, the configuration registers, the registered dout and the counter.

Test Plan:
1. Load pattern 3'b101, len 3, overlap=1. Stream 1,0,1,0,1 with in_valid held high -> dout pulses after bits 3 and 5; match_cnt=2.
2. Same load with overlap=0, same stream -> dout pulses only after bit 3; match_cnt=1. Continue with 1,0,1 -> a second pulse after bit 8.
3. Load 8'b1100_1010, len 8. Send the pattern with in_valid low for 3 cycles between bits 4 and 5 -> exactly one pulse, one cycle after the final valid bit. No pulse during the gaps.
4. Load with CNT_W=2 and pattern len 1 = 1'b1. Send 6 ones -> match_cnt reads 1,2,3,3,3,3. dout pulses 6 times.
5. Load len 3 "101" and send 1,0. Assert rst for one cycle, then send 1 -> no pulse; armed=0 and match_cnt=0 after reset.
6. cfg_load with cfg_len=0, then with cfg_len=MAX_LEN+1 (when representable) -> cfg_err=1, armed=0, input ignored. A following valid load -> cfg_err=0, armed=1.
